// File: rtl/mdu_core_if.sv
// Issue/result bundle between the decode/hazard logic and the multiply/divide unit.
// The slave side is the MDU; the master side is the pipeline (or a testbench).
interface mdu_core_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] In_A;
  logic [31:0] In_B;
  logic        Cancel;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDOp, In_A, In_B, Cancel,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, MDOp, In_A, In_B, Cancel,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mdu_core.sv
// EX-stage multiply/divide unit owning HI/LO. The counter only models latency; the
// arithmetic is combinational on operands latched at issue.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_core_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               issue_s;
  logic [63:0]        smul_s;
  logic [63:0]        umul_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic               b_zero_s;
  logic [31:0]        abs_a_s;
  logic [31:0]        abs_b_s;
  logic [31:0]        sden_s;
  logic [31:0]        uden_s;
  logic [31:0]        smag_q_s;
  logic [31:0]        smag_r_s;
  logic [31:0]        squo_s;
  logic [31:0]        srem_s;
  logic [31:0]        uquo_s;
  logic [31:0]        urem_s;

  assign issue_s = bus.Start & ~bus.Cancel;

  // Products and quotients from the latched operands; signed division works on
  // magnitudes so 0x80000000 / -1 naturally yields 0x80000000 remainder 0.
  always_comb begin
    smul_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    umul_s   = {32'd0, a_q} * {32'd0, b_q};
    a_neg_s  = a_q[31];
    b_neg_s  = b_q[31];
    b_zero_s = (b_q == 32'd0);
    abs_a_s  = a_neg_s ? (32'd0 - a_q) : a_q;
    abs_b_s  = b_neg_s ? (32'd0 - b_q) : b_q;
    sden_s   = b_zero_s ? 32'd1 : abs_b_s;
    uden_s   = b_zero_s ? 32'd1 : b_q;
    smag_q_s = abs_a_s / sden_s;
    smag_r_s = abs_a_s % sden_s;
    squo_s   = (a_neg_s ^ b_neg_s) ? (32'd0 - smag_q_s) : smag_q_s;
    srem_s   = a_neg_s ? (32'd0 - smag_r_s) : smag_r_s;
    uquo_s   = a_q / uden_s;
    urem_s   = a_q % uden_s;
  end

  // Next-state, operand latch, HI/LO update and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (issue_s) begin
          case (bus.MDOp)
            OP_MULT, OP_MULTU: begin
              op_d    = bus.MDOp;
              a_d     = bus.In_A;
              b_d     = bus.In_B;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = bus.MDOp;
              a_d     = bus.In_A;
              b_d     = bus.In_B;
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = bus.In_A;
            OP_MTLO: lo_d = bus.In_A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          // A zero divisor still consumes the full latency but leaves HI/LO alone.
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = smul_s;
            OP_MULTU: {hi_d, lo_d} = umul_s;
            OP_DIV: begin
              if (b_zero_s) begin
                hi_d = hi_q;
                lo_d = lo_q;
              end else begin
                hi_d = srem_s;
                lo_d = squo_s;
              end
            end
            OP_DIVU: begin
              if (b_zero_s) begin
                hi_d = hi_q;
                lo_d = lo_q;
              end else begin
                hi_d = urem_s;
                lo_d = uquo_s;
              end
            end
            default: begin
              hi_d = hi_q;
              lo_d = lo_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Directed bench for mdu_core: latency, HI/LO results, mthi/mtlo, cancel and reset behaviour.
module tb_mdu_core;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mdu_core_if bus ();

  mdu_core #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    bus.Start  = 1'b1;
    bus.MDOp   = op;
    bus.In_A   = a;
    bus.In_B   = b;
    bus.Cancel = cancel;
    tick();
    bus.Start  = 1'b0;
    bus.MDOp   = 3'd0;
    bus.Cancel = 1'b0;
    bus.In_A   = 32'hDEADBEEF;
    bus.In_B   = 32'hDEADBEEF;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc,
                        input logic [31:0] hi, input logic [31:0] lo);
    int n;
    drive(op, a, b, 1'b0);
    chk({tag, "_done_low"}, 32'(bus.Done), 32'd0);
    wait_idle(n);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(cyc));
    chk({tag, "_done"}, 32'(bus.Done), 32'd1);
    chk({tag, "_hi"}, bus.HI, hi);
    chk({tag, "_lo"}, bus.LO, lo);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.MDOp   = 3'd0;
    bus.In_A   = 32'd0;
    bus.In_B   = 32'd0;
    bus.Cancel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);

    // Back-to-back chain: each op issues in the Done cycle of the previous one.
    run_op("mult_m3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    drive(3'd5, 32'h11, 32'd0, 1'b0);
    chk("mthi11_hi", bus.HI, 32'h11);
    chk("mthi11_lo", bus.LO, 32'd3);
    chk("mthi11_busy", 32'(bus.Busy), 32'd0);
    drive(3'd6, 32'h22, 32'd0, 1'b0);
    chk("mtlo22_lo", bus.LO, 32'h22);
    chk("mtlo22_hi", bus.HI, 32'h11);
    chk("mtlo22_done", 32'(bus.Done), 32'd0);

    run_op("divu_by0", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    drive(3'd5, 32'hAAAA5555, 32'd0, 1'b0);
    chk("mthi_hi", bus.HI, 32'hAAAA5555);
    chk("mthi_lo", bus.LO, 32'h80000000);
    chk("mthi_busy", 32'(bus.Busy), 32'd0);
    chk("mthi_done", 32'(bus.Done), 32'd0);

    // mtlo attempted while a mult is in flight must be dropped.
    drive(3'd1, 32'd6, 32'd7, 1'b0);
    tick();
    bus.Start = 1'b1;
    bus.MDOp  = 3'd6;
    bus.In_A  = 32'h1234;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = 3'd0;
    chk("inj_lo_mid", bus.LO, 32'h80000000);
    wait_idle(n);
    chk("inj_busy_cycles", 32'(n + 2), 32'd5);
    chk("inj_done", 32'(bus.Done), 32'd1);
    chk("inj_hi", bus.HI, 32'd0);
    chk("inj_lo", bus.LO, 32'd42);

    // Cancelled issue: nothing starts, HI/LO untouched.
    tick();
    drive(3'd1, 32'd3, 32'd3, 1'b1);
    chk("cancel_busy", 32'(bus.Busy), 32'd0);
    tick();
    chk("cancel_done", 32'(bus.Done), 32'd0);
    chk("cancel_hi", bus.HI, 32'd0);
    chk("cancel_lo", bus.LO, 32'd42);

    // Cancel during RUN does not affect an op already accepted.
    drive(3'd1, 32'h00010000, 32'h00010000, 1'b0);
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    wait_idle(n);
    chk("runcancel_cycles", 32'(n + 1), 32'd5);
    chk("runcancel_done", 32'(bus.Done), 32'd1);
    chk("runcancel_hi", bus.HI, 32'd1);
    chk("runcancel_lo", bus.LO, 32'd0);

    // Reset at cycle 3 of RUN aborts the op.
    tick();
    drive(3'd1, 32'd2, 32'd3, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_done", 32'(bus.Done), 32'd0);
    chk("midrst_hi", bus.HI, 32'd0);
    chk("midrst_lo", bus.LO, 32'd0);
    tick();
    tick();
    tick();
    chk("midrst_done_later", 32'(bus.Done), 32'd0);
    chk("midrst_lo_later", bus.LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_core.md
# mdu_core

Multiply/divide unit in the EX stage of the P7 five-stage MIPS pipeline. It receives the start pulse, operation code and forwarded operands that the decode stage issues for mult/multu/div/divu/mthi/mtlo, and owns the HI/LO registers. It signals Busy so the hazard unit can stall later HI/LO-class instructions. It also honours the exception-cancel signal, so an instruction squashed by an exception never changes HI/LO.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  issue strobe; qualifies MDOp for one cycle
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- In_A  input  32  rs operand (forwarded)
- In_B  input  32  rt operand (forwarded)
- Cancel  input  1  exception flush; when high, a Start in the same cycle is ignored
- Busy  output  1  high while a mult/div is in flight
- Done  output  1  one-cycle pulse; HI/LO hold a new mult/div result
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, RUN.
- IDLE + (Start & !Cancel & MDOp∈1..4):
  - latch the operands and op;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE + (Start & !Cancel & MDOp=5): HI←In_A at this edge; LO unchanged; no Busy.
- IDLE + (Start & !Cancel & MDOp=6): LO←In_A at this edge; HI unchanged; no Busy.
- RUN: decrement the counter every cycle. At the final cycle, write HI/LO and return to IDLE.
- Start while Busy: ignored entirely, including mthi/mtlo. The hazard unit guarantees this never happens; the unit still must not corrupt state if it does.
- Cancel affects only the issue cycle. An op already in RUN completes normally.
- mult: signed 32×32→64, {HI,LO} = product.
- multu: unsigned 32×32→64, {HI,LO} = product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: LO = unsigned quotient; HI = unsigned remainder.
- div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero (div/divu): runs the full DIV_CYCLES with Busy; HI/LO are left unchanged; Done still pulses.
- The result is computed from the latched operands. In_A/In_B may change freely after the issue edge.
- The arithmetic may be combinational on the latched operands. The counter only models latency.

## Timing
- Reset (synchronous): IDLE, counter=0, Busy=0, Done=0, HI=0, LO=0. Reset mid-RUN aborts the op; the result is never written.
- Issue at edge E0 (Start sampled high):
  - Busy=1 in the cycles following E0 through edge E0+N, where N = MULT_CYCLES or DIV_CYCLES;
  - HI/LO update at edge E0+N;
  - Busy=0 and Done=1 in the cycle after E0+N;
  - Done=0 the cycle after that.
- A new Start is accepted in the cycle where Busy=0, i.e. a back-to-back issue right after Done.
- mthi/mtlo: the value is visible on HI/LO in the cycle after the sampling edge. Busy and Done stay 0.
- HI/LO are plain registers, readable every cycle. During RUN they show the previous values.
- Busy is a registered output only; it does not depend combinationally on Start. The stall logic ORs Start in itself.

## Test plan
- Reset, then mult In_A=0xFFFFFFFD (−3), In_B=5 → Busy high for exactly 5 cycles. Next cycle: HI=0xFFFFFFFF, LO=0xFFFFFFF1, Done=1 for one cycle.
- multu 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE. Then div 0xFFFFFFF9 (−7) by 2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also check divu 7/2 → LO=3, HI=1.
- With HI=0x11, LO=0x22, issue divu 7/0 → Busy 10 cycles, Done pulses, HI=0x11 and LO=0x22 unchanged. Then div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0xAAAA5555 → next cycle HI=0xAAAA5555, Busy=0. Start a mult, then assert mtlo 0x1234 at cycle 2 of RUN → ignored; LO equals the product LSW.
- mult issued with Cancel=1 → no Busy, HI/LO unchanged. mult issued, then Cancel pulsed in RUN → completes with the correct product.
- mult started, reset asserted at cycle 3 of RUN → next cycle Busy=0, HI=LO=0, no Done pulse.
